// File: rtl/fec_pkg.sv
// rtl/fec_pkg.sv - shared FEC widths, uplink frame constants and frame-assembler state type
package fec_pkg;

  localparam int UART_MDW        = 8;
  localparam int UART_RX_FAW     = 3;
  localparam int ENC0_DATA_DEPTH = 8;
  localparam int ENC0_DATA_WIDTH = 8;
  localparam int CRC0_WIDTH      = 8;
  localparam int ENC1_DATA_DEPTH = 4;
  localparam int ENC1_DATA_WIDTH = 4;
  localparam int CRC1_WIDTH      = 4;

  localparam int UL_FRAME0_BYTES = 10;
  localparam int UL_FRAME1_BYTES = 5;

  typedef enum logic [2:0] {
    UL_IDLE,
    UL_COLLECT,
    UL_START,
    UL_WAIT_DEC,
    UL_REPORT
  } ul_frm_state_t;

endpackage

// File: rtl/ul_frame_assembler_if.sv
// rtl/ul_frame_assembler_if.sv - UART receive byte stream feeding the uplink frame assembler
interface ul_frame_assembler_if;

  logic [fec_pkg::UART_MDW-1:0] rx_data;
  logic                         rx_valid;
  logic                         rx_err;

  modport master (output rx_data, output rx_valid, output rx_err);
  modport slave  (input  rx_data, input  rx_valid, input  rx_err);

endinterface

// File: rtl/ul_frame_assembler_gap_timer.sv
// rtl/ul_frame_assembler_gap_timer.sv - inter-byte idle counter, expires after BYTE_TIMEOUT idle cycles
module ul_gap_timer #(
  parameter int BYTE_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int CW = (BYTE_TIMEOUT > 2) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTE_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // An arriving byte beats expiry in the same cycle.
  assign o_expired = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/ul_frame_assembler.sv
// rtl/ul_frame_assembler.sv - collects UART bytes into one FEC frame and sequences decode/status
// Optional inter-byte timeout enabled by defining UL_FRAME_TIMEOUT_EN.
module ul_frame_assembler
  import fec_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 1024,
  parameter int FRAME0_BYTES = UL_FRAME0_BYTES,
  parameter int FRAME1_BYTES = UL_FRAME1_BYTES
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  ul_frame_assembler_if.slave                        rx,
  input  logic                                       enc_sel,
  output logic                                       enc_used,
  output logic [2**UART_RX_FAW-2:0][UART_MDW-1:0]    data_in,
  output logic                                       enc0_start,
  output logic [ENC0_DATA_DEPTH-1:0]                 enc0_row_p,
  output logic [ENC0_DATA_WIDTH-1:0]                 enc0_col_p,
  output logic [CRC0_WIDTH-1:0]                      crc0_data,
  output logic                                       enc1_start,
  output logic [ENC1_DATA_DEPTH-1:0]                 enc1_row_p,
  output logic [ENC1_DATA_WIDTH-1:0]                 enc1_col_p,
  output logic [CRC1_WIDTH-1:0]                      crc1_data,
  input  logic                                       crc0_done,
  input  logic                                       crc0_valid,
  input  logic                                       crc1_done,
  input  logic                                       crc1_valid,
  input  logic                                       uncor_err,
  output logic                                       frame_done,
  output logic                                       frame_ok,
  output logic                                       frame_drop,
  output logic                                       rx_overrun,
  output logic                                       busy
);

  ul_frm_state_t                              r_state;
  logic [3:0]                                 r_byte_cnt;
  logic                                       r_enc_used;
  logic [2**UART_RX_FAW-2:0][UART_MDW-1:0]    r_data_in;
  logic [ENC0_DATA_DEPTH-1:0]                 r_enc0_row_p;
  logic [ENC0_DATA_WIDTH-1:0]                 r_enc0_col_p;
  logic [CRC0_WIDTH-1:0]                      r_crc0_data;
  logic [ENC1_DATA_DEPTH-1:0]                 r_enc1_row_p;
  logic [ENC1_DATA_WIDTH-1:0]                 r_enc1_col_p;
  logic [CRC1_WIDTH-1:0]                      r_crc1_data;
  logic                                       r_enc0_start;
  logic                                       r_enc1_start;
  logic                                       r_frame_done;
  logic                                       r_frame_ok;
  logic                                       r_frame_drop;
  logic                                       r_rx_overrun;

  logic       w_timeout;
  logic [3:0] w_last_idx;
  logic       w_done;
  logic       w_valid;

`ifdef UL_FRAME_TIMEOUT_EN
  ul_gap_timer #(.BYTE_TIMEOUT(BYTE_TIMEOUT)) u_gap_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (r_state == UL_COLLECT),
    .i_clr     (rx.rx_valid),
    .o_expired (w_timeout)
  );
`else
  // No gap timer: constant false for every legal BYTE_TIMEOUT.
  assign w_timeout = (BYTE_TIMEOUT == 0);
`endif

  assign w_last_idx = r_enc_used ? 4'(FRAME1_BYTES - 1) : 4'(FRAME0_BYTES - 1);
  assign w_done     = r_enc_used ? crc1_done  : crc0_done;
  assign w_valid    = r_enc_used ? crc1_valid : crc0_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= UL_IDLE;
      r_byte_cnt   <= '0;
      r_enc_used   <= 1'b0;
      r_data_in    <= '0;
      r_enc0_row_p <= '0;
      r_enc0_col_p <= '0;
      r_crc0_data  <= '0;
      r_enc1_row_p <= '0;
      r_enc1_col_p <= '0;
      r_crc1_data  <= '0;
      r_enc0_start <= 1'b0;
      r_enc1_start <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_drop <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_enc0_start <= 1'b0;
      r_enc1_start <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_drop <= 1'b0;
      r_rx_overrun <= 1'b0;
      case (r_state)
        UL_IDLE: begin
          if (rx.rx_valid && !rx.rx_err) begin
            r_enc_used   <= enc_sel;
            r_data_in[0] <= rx.rx_data;
            r_byte_cnt   <= 4'd1;
            r_state      <= UL_COLLECT;
          end
        end
        UL_COLLECT: begin
          if (rx.rx_err) begin
            r_byte_cnt   <= '0;
            r_frame_drop <= 1'b1;
            r_state      <= UL_IDLE;
          end else if (rx.rx_valid) begin
            if (!r_enc_used) begin
              case (r_byte_cnt)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6:
                  r_data_in[r_byte_cnt[2:0]] <= rx.rx_data;
                4'd7: r_crc0_data  <= rx.rx_data;
                4'd8: r_enc0_row_p <= rx.rx_data;
                4'd9: r_enc0_col_p <= rx.rx_data;
                default: ;
              endcase
            end else begin
              case (r_byte_cnt)
                4'd0, 4'd1, 4'd2:
                  r_data_in[r_byte_cnt[2:0]] <= rx.rx_data;
                4'd3: r_crc1_data <= rx.rx_data[3:0];
                4'd4: begin
                  r_enc1_row_p <= rx.rx_data[3:0];
                  r_enc1_col_p <= rx.rx_data[7:4];
                end
                default: ;
              endcase
            end
            if (r_byte_cnt == w_last_idx) begin
              r_byte_cnt   <= '0;
              r_enc0_start <= !r_enc_used;
              r_enc1_start <= r_enc_used;
              r_state      <= UL_START;
            end else begin
              r_byte_cnt <= r_byte_cnt + 4'd1;
            end
          end else if (w_timeout) begin
            r_byte_cnt   <= '0;
            r_frame_drop <= 1'b1;
            r_state      <= UL_IDLE;
          end
        end
        UL_START: begin
          r_rx_overrun <= rx.rx_valid;
          r_state      <= UL_WAIT_DEC;
        end
        UL_WAIT_DEC: begin
          r_rx_overrun <= rx.rx_valid;
          if (w_done) begin
            r_frame_ok   <= w_valid && !uncor_err;
            r_frame_done <= 1'b1;
            r_state      <= UL_REPORT;
          end
        end
        UL_REPORT: begin
          r_rx_overrun <= rx.rx_valid;
          r_state      <= UL_IDLE;
        end
        default: r_state <= UL_IDLE;
      endcase
    end
  end

  assign enc_used   = r_enc_used;
  assign data_in    = r_data_in;
  assign enc0_start = r_enc0_start;
  assign enc0_row_p = r_enc0_row_p;
  assign enc0_col_p = r_enc0_col_p;
  assign crc0_data  = r_crc0_data;
  assign enc1_start = r_enc1_start;
  assign enc1_row_p = r_enc1_row_p;
  assign enc1_col_p = r_enc1_col_p;
  assign crc1_data  = r_crc1_data;
  assign frame_done = r_frame_done;
  assign frame_ok   = r_frame_ok;
  assign frame_drop = r_frame_drop;
  assign rx_overrun = r_rx_overrun;
  assign busy       = (r_state != UL_IDLE);

endmodule

// File: tb/tb_ul_frame_assembler.sv
// tb/tb_ul_frame_assembler.sv - directed self-checking bench for ul_frame_assembler
module tb_ul_frame_assembler;

  logic        clk;
  logic        rst_n;
  logic        enc_sel;
  logic        enc_used;
  logic [6:0][7:0] data_in;
  logic        enc0_start, enc1_start;
  logic [7:0]  enc0_row_p, enc0_col_p, crc0_data;
  logic [3:0]  enc1_row_p, enc1_col_p, crc1_data;
  logic        crc0_done, crc0_valid, crc1_done, crc1_valid, uncor_err;
  logic        frame_done, frame_ok, frame_drop, rx_overrun, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_drop  = 0;
  int n_done  = 0;
  int n_start0 = 0;

  ul_frame_assembler_if u_rx();

  ul_frame_assembler #(.BYTE_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (u_rx.slave),
    .enc_sel    (enc_sel),
    .enc_used   (enc_used),
    .data_in    (data_in),
    .enc0_start (enc0_start),
    .enc0_row_p (enc0_row_p),
    .enc0_col_p (enc0_col_p),
    .crc0_data  (crc0_data),
    .enc1_start (enc1_start),
    .enc1_row_p (enc1_row_p),
    .enc1_col_p (enc1_col_p),
    .crc1_data  (crc1_data),
    .crc0_done  (crc0_done),
    .crc0_valid (crc0_valid),
    .crc1_done  (crc1_done),
    .crc1_valid (crc1_valid),
    .uncor_err  (uncor_err),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .frame_drop (frame_drop),
    .rx_overrun (rx_overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_drop) n_drop++;
    if (frame_done) n_done++;
    if (enc0_start) n_start0++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    u_rx.rx_data  = b;
    u_rx.rx_valid = 1'b1;
    step();
    u_rx.rx_valid = 1'b0;
  endtask

  task automatic pulse_done0(input logic valid, input logic uerr);
    crc0_done = 1'b1; crc0_valid = valid; uncor_err = uerr;
    step();
    crc0_done = 1'b0; crc0_valid = 1'b0; uncor_err = 1'b0;
  endtask

  logic [7:0] f0 [10];
  logic [7:0] f1 [5];
  logic [7:0] f2 [10];
  int drop_base;

  initial begin
    rst_n = 1'b0; enc_sel = 1'b0;
    u_rx.rx_data = '0; u_rx.rx_valid = 1'b0; u_rx.rx_err = 1'b0;
    crc0_done = 0; crc0_valid = 0; crc1_done = 0; crc1_valid = 0; uncor_err = 0;
    f0 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hA5, 8'h3C, 8'hC3};
    f1 = '{8'h1A, 8'h2B, 8'h3C, 8'h0D, 8'h96};
    f2 = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h5A, 8'h66, 8'h99};
    step(); step();
    rst_n = 1'b1;
    step();

    check("rst_busy", busy, 0);
    check("rst_data_in", data_in, 0);
    check("rst_crc0", crc0_data, 0);
    check("rst_flags", {enc_used, enc0_start, enc1_start, frame_done, frame_ok, frame_drop, rx_overrun}, 0);

    // Mode 0 frame
    enc_sel = 1'b0;
    for (int i = 0; i < 10; i++) send(f0[i]);
    check("m0_start0", enc0_start, 1);
    check("m0_start1", enc1_start, 0);
    check("m0_data6", data_in[6], 8'h06);
    check("m0_data0", data_in[0], 8'h00);
    check("m0_crc", crc0_data, 8'hA5);
    check("m0_row", enc0_row_p, 8'h3C);
    check("m0_col", enc0_col_p, 8'hC3);
    step();
    check("m0_start_1cyc", enc0_start, 0);
    crc1_done = 1'b1; crc1_valid = 1'b1;
    step();
    crc1_done = 1'b0; crc1_valid = 1'b0;
    check("m0_other_done_ignored", {busy, frame_done}, 2'b10);
    pulse_done0(1'b1, 1'b0);
    check("m0_done_ok", {frame_done, frame_ok}, 2'b11);
    step();
    check("m0_idle", {busy, frame_done}, 2'b00);

    // Mode 1 frame, enc_sel flipped after byte 0
    enc_sel = 1'b1;
    send(f1[0]);
    enc_sel = 1'b0;
    for (int i = 1; i < 5; i++) send(f1[i]);
    check("m1_start", {enc1_start, enc0_start}, 2'b10);
    check("m1_enc_used", enc_used, 1);
    check("m1_nibbles", {data_in[0][3:0], data_in[1][3:0], data_in[2][3:0]}, 12'hABC);
    check("m1_crc", crc1_data, 4'hD);
    check("m1_row", enc1_row_p, 4'h6);
    check("m1_col", enc1_col_p, 4'h9);
    check("m1_crc0_held", crc0_data, 8'hA5);
    step();
    crc1_done = 1'b1; crc1_valid = 1'b1;
    step();
    crc1_done = 1'b0; crc1_valid = 1'b0;
    check("m1_done_ok", {frame_done, frame_ok}, 2'b11);
    step();
    check("m1_start0_count", n_start0, 1);

    // rx_err after 4 bytes, colliding with a byte
    drop_base = n_drop;
    enc_sel = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
    u_rx.rx_err = 1'b1;
    send(8'hEE);
    u_rx.rx_err = 1'b0;
    check("err_drop", frame_drop, 1);
    check("err_busy", busy, 0);
    step(); step();
    check("err_drop_once", n_drop - drop_base, 1);

    for (int i = 0; i < 10; i++) send(f2[i]);
    check("re_data0", data_in[0], 8'h20);
    check("re_data6", data_in[6], 8'h26);
    check("re_tail", {crc0_data, enc0_row_p, enc0_col_p}, 24'h5A6699);
    step();
    send(8'h77);
    check("ovr_pulse", rx_overrun, 1);
    check("ovr_data0", data_in[0], 8'h20);
    pulse_done0(1'b1, 1'b1);
    check("uncor_done", {frame_done, frame_ok}, 2'b10);
    step();

    // Inter-byte gap
    drop_base = n_drop;
    for (int i = 0; i < 3; i++) send(8'h40 + 8'(i));
    for (int i = 0; i < 18; i++) step();
`ifdef UL_FRAME_TIMEOUT_EN
    check("to_busy", busy, 0);
    check("to_drop", n_drop - drop_base, 1);
`else
    check("to_busy", busy, 1);
    check("to_drop", n_drop - drop_base, 0);
`endif

    // Reset during COLLECT
    drop_base = n_drop;
    send(8'h50);
    send(8'h51);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data", data_in, 0);
    check("rst_mid_regs", {enc0_row_p, enc0_col_p, crc0_data, enc1_row_p, enc1_col_p, crc1_data, enc_used}, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_mid_nodrop", n_drop - drop_base, 0);
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
    check("post_rst_start", enc0_start, 1);
    check("post_rst_data3", data_in[3], 8'h33);
    check("post_rst_col", enc0_col_p, 8'h39);
    step();
    pulse_done0(1'b1, 1'b0);
    check("post_rst_done", {frame_done, frame_ok}, 2'b11);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ul_frame_assembler.md
# ul_frame_assembler

Uplink frame assembler that sits directly upstream of the uplink FEC engine. It collects UART receive bytes into one FEC frame: 64-bit mode is 7 data bytes, a CRC byte, a row-parity byte and a column-parity byte; 16-bit mode is 3 data nibbles, a CRC nibble and a parity byte. It presents the packed data, parity and CRC to the engine, pulses the matching decoder start, and holds everything stable until the engine reports CRC completion. It then reports a per-frame status.

## Interface
Parameters:
- BYTE_TIMEOUT, 1024: idle cycles allowed between bytes inside a frame; minimum 2.
- FRAME0_BYTES, 10: bytes per 64-bit-mode frame (fixed).
- FRAME1_BYTES, 5: bytes per 16-bit-mode frame (fixed).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - rst_n  in  1  asynchronous active-low reset.
- UART side:
  - rx_data  in  UART_MDW  received byte.
  - rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
  - rx_err  in  1  UART framing or parity error strobe.
- Mode and engine data:
  - enc_sel  in  1  requested mode: 0 = 64-bit, 1 = 16-bit.
  - enc_used  out  1  mode latched for the current frame; drives the engine's enc_used.
  - data_in  out  [2**UART_RX_FAW-2:0][UART_MDW]  data bytes 0..6.
- 64-bit decoding cluster:
  - enc0_start  out  1  decoder-0 start pulse.
  - enc0_row_p  out  ENC0_DATA_DEPTH  row parity.
  - enc0_col_p  out  ENC0_DATA_WIDTH  column parity.
  - crc0_data  out  CRC0_WIDTH  received CRC.
- 16-bit decoding cluster:
  - enc1_start, enc1_row_p, enc1_col_p, crc1_data: the same outputs for cluster 1, with ENC1_*/CRC1_* widths.
- Engine status inputs:
  - crc0_done, crc0_valid, crc1_done, crc1_valid, uncor_err  in  1 each  engine status.
- Frame status outputs:
  - frame_done  out  1  one-cycle pulse per completed frame.
  - frame_ok  out  1  valid with frame_done; high when crc_valid && !uncor_err.
  - frame_drop  out  1  pulse when a frame is aborted.
  - rx_overrun  out  1  pulse when a byte arrives while the block is busy.
  - busy  out  1  high in every state except IDLE.

## Operation
- States and transitions: IDLE → COLLECT → START → WAIT_DEC → REPORT → IDLE.
- IDLE:
  - The first rx_valid latches enc_sel into enc_used and stores the byte as byte 0.
  - byte_cnt becomes 1 and the state moves to COLLECT.
- COLLECT: each rx_valid stores rx_data at byte_cnt and increments byte_cnt (4-bit).
- Mode 0 byte map:
  - bytes 0..6 go to data_in[0..6].
  - byte 7 goes to crc0_data.
  - byte 8 goes to enc0_row_p.
  - byte 9 goes to enc0_col_p.
- Mode 1 byte map:
  - bytes 0..2 go to data_in[0..2][3:0]; upper nibbles are stored but ignored.
  - byte 3[3:0] goes to crc1_data.
  - byte 4[3:0] goes to enc1_row_p.
  - byte 4[7:4] goes to enc1_col_p.
- Last byte: when the last byte of the frame is captured (byte_cnt = FRAME_BYTES-1 with rx_valid), the state moves to START.
- START: asserts enc0_start if enc_used = 0, otherwise enc1_start, for exactly one cycle, then moves to WAIT_DEC.
- WAIT_DEC: waits for crc0_done (mode 0) or crc1_done (mode 1). In that cycle the block registers frame_ok = crcX_valid && !uncor_err and moves to REPORT.
- REPORT: frame_done pulses for one cycle with frame_ok valid; the state then returns to IDLE.
- Output hold: data_in, parity, CRC and enc_used hold their values from capture until the next frame overwrites them. They are never cleared between frames.

## Timing
- Reset values: every output is 0, including all data, parity and CRC registers; the state is IDLE and byte_cnt is 0.
- Reset mid-frame aborts the frame silently; frame_drop is not pulsed.
- Start latency: last rx_valid in cycle N → encX_start high in cycle N+1.
- Status latency: crcX_done in cycle M → frame_done and frame_ok high in cycle M+1.
- The done input of the non-active cluster is ignored.
- rx_valid in START, WAIT_DEC or REPORT: the byte is dropped, rx_overrun pulses in the next cycle, and stored data is unchanged.
- rx_err in COLLECT: the state goes to IDLE, byte_cnt clears, and frame_drop pulses in the next cycle. rx_err in IDLE is ignored.
- rx_valid and rx_err in the same cycle: rx_err wins and the byte is discarded.
- enc_sel changes mid-frame have no effect on the current frame.
- No backpressure: rx_valid is accepted in IDLE and COLLECT every cycle, including back-to-back.

## Configuration
- UL_FRAME_TIMEOUT_EN defined:
  - A gap counter runs in COLLECT. It clears on every rx_valid and increments otherwise.
  - When it reaches BYTE_TIMEOUT-1 without a byte, the state goes to IDLE and frame_drop pulses.
  - If rx_valid arrives in the same cycle the counter expires, the byte wins and the counter clears.
- UL_FRAME_TIMEOUT_EN undefined: there is no gap counter, and COLLECT waits indefinitely.

## Structure
- fec_pkg gains the following; they do not go in the module:
  - typedef ul_frm_state_t, the state enum.
  - constants UL_FRAME0_BYTES = 10 and UL_FRAME1_BYTES = 5.
- One sub-module is natural: ul_gap_timer (counter, clear, expiry), instantiated only under UL_FRAME_TIMEOUT_EN.

## Test plan
- Mode 0, bytes 0x00..0x06, crc 0xA5, row 0x3C, col 0xC3:
  - enc0_start high one cycle after byte 9.
  - data_in[6] = 0x06, crc0_data = 0xA5, enc0_row_p = 0x3C, enc0_col_p = 0xC3.
  - crc0_done with crc0_valid = 1 and uncor_err = 0 → frame_done = 1 and frame_ok = 1 next cycle.
- Mode 1, bytes 0x1A, 0x2B, 0x3C, 0x0D, 0x96:
  - data_in[0..2][3:0] = A, B, C; crc1_data = D; enc1_row_p = 6; enc1_col_p = 9.
  - enc1_start pulses; enc0_start stays 0.
- rx_err after 4 bytes of a mode-0 frame:
  - frame_drop pulses once.
  - A following clean 10-byte frame decodes correctly from byte 0.
- rx_valid during WAIT_DEC → rx_overrun pulses and data_in is unchanged. crc0_done with uncor_err = 1 → frame_ok = 0.
- Timeout with UL_FRAME_TIMEOUT_EN and BYTE_TIMEOUT = 16:
  - 3 bytes, then 16 idle cycles → frame_drop and busy = 0.
  - Without the macro, the same stimulus leaves busy = 1.
- Assert rst_n low during COLLECT:
  - All outputs are 0 immediately and frame_drop stays 0.
  - The next frame is assembled normally.
